// File: rtl/decode_stage.sv
// decode_stage
//   Decode stage of an RV32I/RV64I-style in-order pipeline. Each accepted
//   instruction is decoded into a class/flag bundle with its register fields
//   and sign-extended immediate. The result is held in one output register
//   backed by one skid entry, so in_ready never depends combinationally on
//   out_ready.
//
// Parameters
//   XLEN     : width of pc and immediate (32 or 64)
//   ENABLE_M : 1 treats funct7=0000001 on opcode 0110011 as a legal multiply
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : discard every held bundle and this cycle's input
//   in_valid / in_ready   : upstream handshake
//   in_instr, in_pc       : raw instruction word and its address
//   out_valid / out_ready : downstream handshake
//   out_pc, out_rd, out_rs1, out_rs2, out_funct3, out_imm : decoded fields
//   out_flags             : {is_mul, is_system, is_store, is_load, is_alu_imm,
//                            is_auipc, is_lui, is_branch, is_jalr, is_jal,
//                            is_alu_reg, reg_write}
//   out_illegal           : bundle holds an illegal instruction
module decode_stage #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [XLEN-1:0] out_imm,
  output logic [11:0]     out_flags,
  output logic            out_illegal
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int F_MUL = 11, F_SYSTEM = 10, F_STORE = 9, F_LOAD = 8;
  localparam int F_ALU_IMM = 7, F_AUIPC = 6, F_LUI = 5, F_BRANCH = 4;
  localparam int F_JALR = 3, F_JAL = 2, F_ALU_REG = 1, F_REG_WRITE = 0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [11:0]     flags;
    logic            illegal;
  } bundle_t;

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [63:0] immI, immS, immB, immU, immJ;
  logic [10:0] classBits;
  logic        decIllegal;
  bundle_t     decBundle;

  assign opcode = in_instr[6:0];
  assign funct7 = in_instr[31:25];
  assign funct3 = in_instr[14:12];

  // Immediates are built at 64 bits and truncated, which avoids zero-width
  // replications when XLEN is 32.
  assign immI = {{52{in_instr[31]}}, in_instr[31:20]};
  assign immS = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign immB = {{51{in_instr[31]}}, in_instr[31], in_instr[7],
                 in_instr[30:25], in_instr[11:8], 1'b0};
  assign immU = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
  assign immJ = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12],
                 in_instr[20], in_instr[30:21], 1'b0};

  // Combinational decode of the incoming word. Illegal words keep their raw
  // fields and pc but carry no class bits, no reg_write and a zero immediate.
  always_comb begin
    classBits  = '0;
    decIllegal = 1'b0;
    decBundle  = '0;
    decBundle.pc     = in_pc;
    decBundle.rd     = in_instr[11:7];
    decBundle.rs1    = in_instr[19:15];
    decBundle.rs2    = in_instr[24:20];
    decBundle.funct3 = funct3;

    unique case (opcode)
      OP_REG: begin
        if (funct7 == 7'b0000000)
          classBits[F_ALU_REG-1] = 1'b1;
        else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
          classBits[F_ALU_REG-1] = 1'b1;
        else if (funct7 == 7'b0000001 && ENABLE_M)
          classBits[F_MUL-1] = 1'b1;
        else
          decIllegal = 1'b1;
      end
      OP_IMM:    begin classBits[F_ALU_IMM-1] = 1'b1; decBundle.imm = immI[XLEN-1:0]; end
      OP_LOAD:   begin classBits[F_LOAD-1]    = 1'b1; decBundle.imm = immI[XLEN-1:0]; end
      OP_STORE:  begin classBits[F_STORE-1]   = 1'b1; decBundle.imm = immS[XLEN-1:0]; end
      OP_BRANCH: begin classBits[F_BRANCH-1]  = 1'b1; decBundle.imm = immB[XLEN-1:0]; end
      OP_JALR:   begin classBits[F_JALR-1]    = 1'b1; decBundle.imm = immI[XLEN-1:0]; end
      OP_JAL:    begin classBits[F_JAL-1]     = 1'b1; decBundle.imm = immJ[XLEN-1:0]; end
      OP_LUI:    begin classBits[F_LUI-1]     = 1'b1; decBundle.imm = immU[XLEN-1:0]; end
      OP_AUIPC:  begin classBits[F_AUIPC-1]   = 1'b1; decBundle.imm = immU[XLEN-1:0]; end
      OP_SYSTEM: begin classBits[F_SYSTEM-1]  = 1'b1; decBundle.imm = immI[XLEN-1:0]; end
      default:   decIllegal = 1'b1;
    endcase

    // Every listed opcode already ends in 2'b11; the explicit test keeps the
    // compressed-encoding rule visible.
    if (in_instr[1:0] != 2'b11)
      decIllegal = 1'b1;

    if (decIllegal) begin
      decBundle.imm     = '0;
      decBundle.illegal = 1'b1;
    end else begin
      decBundle.flags[11:1] = classBits;
      decBundle.flags[F_REG_WRITE] = (in_instr[11:7] != 5'd0) &&
        (classBits[F_ALU_REG-1] || classBits[F_MUL-1] || classBits[F_ALU_IMM-1] ||
         classBits[F_LOAD-1] || classBits[F_JALR-1] || classBits[F_JAL-1] ||
         classBits[F_LUI-1] || classBits[F_AUIPC-1]);
    end
  end

  bundle_t outBundle_q, outBundle_d;
  bundle_t skidBundle_q, skidBundle_d;
  logic    outValid_q, outValid_d;
  logic    skidValid_q, skidValid_d;
  logic    accept;

  assign in_ready = !skidValid_q;
  assign accept   = in_valid && in_ready;

  // Output register plus skid entry. The skid only fills when the output is
  // stalled, so an empty output never coexists with a full skid; flush wins
  // over every other event including an accept in the same cycle.
  always_comb begin
    outBundle_d  = outBundle_q;
    skidBundle_d = skidBundle_q;
    outValid_d   = outValid_q;
    skidValid_d  = skidValid_q;
    if (flush) begin
      outValid_d  = 1'b0;
      skidValid_d = 1'b0;
    end else if (outValid_q && out_ready) begin
      if (skidValid_q) begin
        outBundle_d = skidBundle_q;
        skidValid_d = 1'b0;
      end else if (accept) begin
        outBundle_d = decBundle;
      end else begin
        outValid_d = 1'b0;
      end
    end else if (!outValid_q) begin
      if (accept) begin
        outBundle_d = decBundle;
        outValid_d  = 1'b1;
      end
    end else if (accept) begin
      skidBundle_d = decBundle;
      skidValid_d  = 1'b1;
    end
  end

  // State registers; reset clears both entries and all visible fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outBundle_q  <= '0;
      skidBundle_q <= '0;
      outValid_q   <= 1'b0;
      skidValid_q  <= 1'b0;
    end else begin
      outBundle_q  <= outBundle_d;
      skidBundle_q <= skidBundle_d;
      outValid_q   <= outValid_d;
      skidValid_q  <= skidValid_d;
    end
  end

  assign out_valid   = outValid_q;
  assign out_pc      = outBundle_q.pc;
  assign out_rd      = outBundle_q.rd;
  assign out_rs1     = outBundle_q.rs1;
  assign out_rs2     = outBundle_q.rs2;
  assign out_funct3  = outBundle_q.funct3;
  assign out_imm     = outBundle_q.imm;
  assign out_flags   = outBundle_q.flags;
  assign out_illegal = outBundle_q.illegal;

endmodule
